fw_tile_feeder: RTL and testbench

Parametrised front-end for the fw core. It buffers one phase's worth of matrix tiles, packs each row into LANES entries of DW bits, and streams them to the core's inD/in_valid/phase inputs. It honours the core's inhibit backpressure. This is the generalised successor of the fixed 8x8, 4-lane, single-phase input sequence used so far.

---
 rtl/fw_pkg.sv | 36 +++
 rtl/fw_feeder_buf.sv | 47 ++++
 rtl/fw_tile_feeder.sv | 211 +++++++++++++++++++++
 tb/tb_fw_tile_feeder.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fw_pkg.sv
// ============================================================================
//  Module      : fw_pkg
//  Description : Shared defaults, phase codes, FSM states and tiles-per-phase
//                lookup for the fw tile feeder.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fw_pkg;

    localparam int FW_DW    = 16;
    localparam int FW_LANES = 4;

    localparam logic [1:0] PH_00 = 2'b00;
    localparam logic [1:0] PH_01 = 2'b01;
    localparam logic [1:0] PH_10 = 2'b10;
    localparam logic [1:0] PH_11 = 2'b11;

    typedef logic [1:0] fw_state_t;

    localparam fw_state_t ST_IDLE   = 2'd0;
    localparam fw_state_t ST_LOAD   = 2'd1;
    localparam fw_state_t ST_STREAM = 2'd2;
    localparam fw_state_t ST_DONE   = 2'd3;

    function automatic logic [1:0] tiles_per_phase(input logic [1:0] ph);
        case (ph)
            PH_00:        return 2'd1;
            PH_01, PH_10: return 2'd2;
            default:      return 2'd3;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/fw_feeder_buf.sv
// ============================================================================
//  Module      : fw_feeder_buf
//  Description : Simple dual-port word buffer, synchronous write and
//                registered (enable-gated) read.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fw_feeder_buf #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 48,
    parameter int AW    = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_wr_en,
    input  logic [AW-1:0]    i_wr_addr,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    input  logic [AW-1:0]    i_rd_addr,
    output logic [WIDTH-1:0] o_rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rd_data;

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // The read register doubles as the feeder's output word, so it resets
    // and holds whenever no read is requested.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_data <= '0;
        end else if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

`default_nettype wire

// File: rtl/fw_tile_feeder.sv
// ============================================================================
//  Module      : fw_tile_feeder
//  Description : Buffers one phase of N x N tiles and streams LANES-wide
//                words to the fw core, honouring its inhibit backpressure.
//                Optional macro FW_FEEDER_DIAG_ZERO_EN zeroes diagonal lanes.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fw_tile_feeder
    import fw_pkg::*;
#(
    parameter int DW        = FW_DW,
    parameter int LANES     = FW_LANES,
    parameter int N         = 8,
    parameter int MAX_TILES = 3
) (
    input  logic                                         clk,
    input  logic                                         reset,
    input  logic                                         start,
    input  logic [1:0]                                   phase_in,
    input  logic                                         wr_en,
    input  logic [LANES*DW-1:0]                          wr_data,
    input  logic                                         inhibit,
    output logic [LANES*DW-1:0]                          outD,
    output logic                                         out_valid,
    output logic [1:0]                                   phase,
    output logic                                         busy,
    output logic                                         done,
    output logic [$clog2(MAX_TILES*N*N/LANES+1)-1:0]     load_cnt
);

    localparam int c_WPT   = N * N / LANES;
    localparam int c_WPR   = N / LANES;
    localparam int c_DEPTH = MAX_TILES * c_WPT;
    localparam int c_CW    = $clog2(c_DEPTH + 1);
    localparam int c_AW    = (c_DEPTH > 1) ? $clog2(c_DEPTH) : 1;
    localparam int c_WORD  = LANES * DW;
    localparam logic [c_CW-1:0] c_ONE = {{(c_CW-1){1'b0}}, 1'b1};

    fw_state_t          r_state;
    fw_state_t          w_next_state;
    logic [1:0]         r_phase;
    logic [c_CW-1:0]    r_load_cnt;
    logic [c_CW-1:0]    r_rd_ptr;
    logic               r_out_valid;
    logic               r_done;
    logic [LANES-1:0]   r_mask;
    logic [LANES-1:0]   w_lane_mask;
    logic [c_CW-1:0]    w_total;
    logic               w_take_start;
    logic               w_wr_en;
    logic               w_issue;
    logic               w_busy;
    logic [c_WORD-1:0]  w_rd_data;

    assign w_total = c_CW'(c_WPT * int'(tiles_per_phase(r_phase)));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next_state = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (wr_en && ((r_load_cnt + c_ONE) == w_total)) begin
                    w_next_state = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (!inhibit && (r_rd_ptr == (w_total - c_ONE))) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        w_take_start = 1'b0;
        w_wr_en      = 1'b0;
        w_issue      = 1'b0;
        w_busy       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_take_start = start;
            end
            ST_LOAD: begin
                w_wr_en = wr_en;
                w_busy  = 1'b1;
            end
            ST_STREAM: begin
                w_issue = !inhibit;
                w_busy  = 1'b1;
            end
            default: begin
                w_busy = 1'b0;
            end
        endcase
    end

    // The DONE state's output appears one edge later, after the last word's
    // valid cycle, so done never overlaps out_valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_phase     <= 2'b00;
            r_load_cnt  <= '0;
            r_rd_ptr    <= '0;
            r_out_valid <= 1'b0;
            r_done      <= 1'b0;
            r_mask      <= '0;
        end else begin
            r_done      <= (r_state == ST_DONE);
            r_out_valid <= w_issue;
            if (w_take_start) begin
                r_phase    <= phase_in;
                r_load_cnt <= '0;
                r_rd_ptr   <= '0;
            end
            if (w_wr_en) begin
                r_load_cnt <= r_load_cnt + c_ONE;
            end
            if (w_issue) begin
                r_rd_ptr <= r_rd_ptr + c_ONE;
                r_mask   <= w_lane_mask;
            end
        end
    end

`ifdef FW_FEEDER_DIAG_ZERO_EN
    localparam int c_RW  = (N > 1) ? $clog2(N) : 1;
    localparam int c_CCW = (c_WPR > 1) ? $clog2(c_WPR) : 1;

    logic [c_CCW-1:0] r_col_word;
    logic [c_RW-1:0]  r_row;

    // Tile-relative position of the word at rd_ptr; wraps each row and tile.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_col_word <= '0;
            r_row      <= '0;
        end else if (w_take_start) begin
            r_col_word <= '0;
            r_row      <= '0;
        end else if (w_issue) begin
            if (r_col_word == c_CCW'(c_WPR - 1)) begin
                r_col_word <= '0;
                r_row      <= (r_row == c_RW'(N - 1)) ? '0 : r_row + 1'b1;
            end else begin
                r_col_word <= r_col_word + 1'b1;
            end
        end
    end

    always_comb begin
        w_lane_mask = '0;
        for (int l = 0; l < LANES; l++) begin
            w_lane_mask[l] = ((int'(r_col_word) * LANES + l) == int'(r_row));
        end
    end
`else
    always_comb begin
        w_lane_mask = '0;
    end
`endif

    fw_feeder_buf #(
        .WIDTH (c_WORD),
        .DEPTH (c_DEPTH),
        .AW    (c_AW)
    ) u_buf (
        .clk       (clk),
        .rst       (reset),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (r_load_cnt[c_AW-1:0]),
        .i_wr_data (wr_data),
        .i_rd_en   (w_issue),
        .i_rd_addr (r_rd_ptr[c_AW-1:0]),
        .o_rd_data (w_rd_data)
    );

    generate
        for (genvar g = 0; g < LANES; g++) begin : g_lane
            assign outD[g*DW +: DW] = r_mask[g] ? '0 : w_rd_data[g*DW +: DW];
        end
    endgenerate

    assign out_valid = r_out_valid;
    assign phase     = r_phase;
    assign busy      = w_busy;
    assign done      = r_done;
    assign load_cnt  = r_load_cnt;

endmodule

`default_nettype wire

// File: tb/tb_fw_tile_feeder.sv
// ============================================================================
//  Module      : tb_fw_tile_feeder
//  Description : Directed/randomised bench for fw_tile_feeder, default
//                parameters (DW=16, LANES=4, N=8, MAX_TILES=3).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fw_tile_feeder;

    localparam int DW    = 16;
    localparam int LANES = 4;
    localparam int N     = 8;
    localparam int WPT   = N * N / LANES;
    localparam int CW    = 6;

    logic                clk = 1'b0;
    logic                reset;
    logic                start;
    logic [1:0]          phase_in;
    logic                wr_en;
    logic [LANES*DW-1:0] wr_data;
    logic                inhibit;
    logic [LANES*DW-1:0] outD;
    logic                out_valid;
    logic [1:0]          phase;
    logic                busy;
    logic                done;
    logic [CW-1:0]       load_cnt;

    int checks   = 0;
    int failures = 0;

    logic [63:0] words [48];
    logic [63:0] got   [48];

    fw_tile_feeder #(
        .DW        (DW),
        .LANES     (LANES),
        .N         (N),
        .MAX_TILES (3)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .phase_in  (phase_in),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .inhibit   (inhibit),
        .outD      (outD),
        .out_valid (out_valid),
        .phase     (phase),
        .busy      (busy),
        .done      (done),
        .load_cnt  (load_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int tiles(input logic [1:0] ph);
        if (ph == 2'b00) return 1;
        if (ph == 2'b11) return 3;
        return 2;
    endfunction

    // Reference: word k of the phase is row-major within its tile.
    function automatic logic [63:0] exp_word(input logic [63:0] d, input int k);
        logic [63:0] r;
`ifdef FW_FEEDER_DIAG_ZERO_EN
        int wt;
        int row;
        int cb;
`endif
        r = d;
`ifdef FW_FEEDER_DIAG_ZERO_EN
        wt  = k % WPT;
        row = wt / (N / LANES);
        cb  = (wt % (N / LANES)) * LANES;
        for (int l = 0; l < LANES; l++) begin
            if (cb + l == row) r[l*DW +: DW] = '0;
        end
`else
        if (k < 0) r = '0;
`endif
        return r;
    endfunction

    // dmode: 0 random with gaps, 1 fixed first word, 2 all 0x0063
    task automatic do_load(input logic [1:0] ph, input int dmode);
        int total;
        total    = tiles(ph) * WPT;
        start    = 1'b1;
        phase_in = ph;
        wr_en    = 1'b1;
        wr_data  = 64'hdead_beef_dead_beef;
        tick();
        start = 1'b0;
        wr_en = 1'b0;
        check("start_busy", {63'b0, busy}, 64'd1);
        check("start_phase", {62'b0, phase}, {62'b0, ph});
        check("start_lcnt", {58'b0, load_cnt}, 64'd0);
        for (int i = 0; i < total; i++) begin
            case (dmode)
                1:       words[i] = (i == 0) ? 64'h004e_0057_0054_0000 : {$urandom, $urandom};
                2:       words[i] = 64'h0063_0063_0063_0063;
                default: words[i] = {$urandom, $urandom};
            endcase
            if (dmode == 0 && $urandom_range(3) == 0) begin
                wr_en    = 1'b0;
                start    = 1'b1;
                phase_in = ~ph;
                tick();
            end
            start   = 1'b0;
            wr_en   = 1'b1;
            wr_data = words[i];
            tick();
        end
        wr_en = 1'b0;
        start = 1'b0;
        check("load_cnt_end", {58'b0, load_cnt}, 64'(total));
    endtask

    // imode: 0 no inhibit, 1 alternate, 2 random plus ignored start/wr_en
    task automatic do_stream(input logic [1:0] ph, input int imode, input bit hold_last, input int stop_after);
        int total;
        int k;
        int cyc;
        int hold;
        bit inh;
        logic [63:0] last;
        total = tiles(ph) * WPT;
        k     = 0;
        cyc   = 0;
        hold  = 0;
        last  = '0;
        while (k < total && cyc < 40 * total) begin
            case (imode)
                0:       inh = 1'b0;
                1:       inh = (cyc % 2) == 1;
                default: inh = $urandom_range(1) == 1;
            endcase
            if (hold_last && k == total - 1 && hold < 3) begin
                inh = 1'b1;
                hold++;
            end
            inhibit = inh;
            if (imode == 2) begin
                start    = $urandom_range(1) == 1;
                phase_in = ~ph;
                wr_en    = $urandom_range(1) == 1;
                wr_data  = {$urandom, $urandom};
            end
            tick();
            check("valid", {63'b0, out_valid}, {63'b0, ~inh});
            check("phase_hold", {62'b0, phase}, {62'b0, ph});
            check("lcnt_hold", {58'b0, load_cnt}, 64'(total));
            check("no_done", {63'b0, done}, 64'd0);
            if (!inh) begin
                last   = exp_word(words[k], k);
                check("data", outD, last);
                got[k] = outD;
                k++;
            end else if (k > 0) begin
                check("data_hold", outD, last);
            end
            check("busy_stream", {63'b0, busy}, {63'b0, k < total});
            cyc++;
            if (k == stop_after) begin
                start = 1'b0;
                wr_en = 1'b0;
                return;
            end
        end
        start   = 1'b0;
        wr_en   = 1'b0;
        inhibit = 1'b0;
        if (k < total) check("stream_timeout", 64'(k), 64'(total));
        tick();
        check("done_pulse", {63'b0, done}, 64'd1);
        check("done_valid", {63'b0, out_valid}, 64'd0);
        check("done_busy", {63'b0, busy}, 64'd0);
        tick();
        check("done_once", {63'b0, done}, 64'd0);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_valid"}, {63'b0, out_valid}, 64'd0);
        check({tag, "_busy"}, {63'b0, busy}, 64'd0);
        check({tag, "_done"}, {63'b0, done}, 64'd0);
        check({tag, "_lcnt"}, {58'b0, load_cnt}, 64'd0);
        check({tag, "_phase"}, {62'b0, phase}, 64'd0);
        check({tag, "_outd"}, outD, 64'd0);
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        phase_in = 2'b00;
        wr_en    = 1'b0;
        wr_data  = '0;
        inhibit  = 1'b0;
        tick();
        tick();
        check_reset_state("rst");
        reset = 1'b0;

        wr_en   = 1'b1;
        wr_data = 64'h1234;
        tick();
        tick();
        wr_en = 1'b0;
        check("idle_wr_lcnt", {58'b0, load_cnt}, 64'd0);
        check("idle_wr_busy", {63'b0, busy}, 64'd0);

        do_load(2'b10, 1);
        do_stream(2'b10, 0, 1'b0, -1);

        do_load(2'b00, 0);
        do_stream(2'b00, 1, 1'b1, -1);

        do_load(2'b11, 0);
        do_stream(2'b11, 2, 1'b1, -1);

        wr_en = 1'b1;
        tick();
        wr_en = 1'b0;
        check("idle_wr_after", {58'b0, load_cnt}, 64'd48);
        check("idle_phase_after", {62'b0, phase}, 64'd3);

        do_load(2'b10, 0);
        do_stream(2'b10, 0, 1'b0, 10);
        reset = 1'b1;
        tick();
        check_reset_state("rst_stream");
        reset = 1'b0;
        tick();
        check("rst_no_done", {63'b0, done}, 64'd0);
        do_load(2'b01, 0);
        do_stream(2'b01, 2, 1'b0, -1);

        start    = 1'b1;
        phase_in = 2'b11;
        tick();
        start   = 1'b0;
        wr_en   = 1'b1;
        wr_data = 64'h5555;
        tick();
        tick();
        wr_en = 1'b0;
        reset = 1'b1;
        tick();
        check_reset_state("rst_load");
        reset = 1'b0;

        do_load(2'b00, 2);
        do_stream(2'b00, 0, 1'b0, -1);
`ifdef FW_FEEDER_DIAG_ZERO_EN
        check("diag_w0", got[0], 64'h0063_0063_0063_0000);
        check("diag_w2", got[2], 64'h0063_0063_0000_0063);
`else
        check("diag_w0", got[0], 64'h0063_0063_0063_0063);
        check("diag_w2", got[2], 64'h0063_0063_0063_0063);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
